// File: rtl/rfdc_adc_integrator.sv
// rfdc_adc_integrator
//   Time-gated integrator for a 16-sample-per-beat RF ADC stream. After an
//   arm, it waits for the system timestamp to reach the latched start time.
//   It then sums window_len valid beats of DC-corrected samples into a
//   saturating ACC_W-bit accumulator. The result is presented on a one-deep
//   AXI-Stream result port.
//
//   Optional feature: define RFDC_ADC_ABS_EN to sum |sample - dc_offset|
//   instead of the signed difference.
//
// Ports
//   clk, resetn                     clock, async active-low reset
//   s_axis_data_*                   256-bit ADC beats (sample 0 in [15:0]), never stalled
//   timestamp                       free-running system cycle counter
//   start_time, window_len          capture window, latched on an accepted arm
//   dc_offset                       signed offset removed from each sample
//   arm, abort                      single-cycle capture control (abort wins)
//   busy, ovf                       not-idle flag, sticky saturation flag
//   m_axis_result_*                 sign-extended accumulator, valid in DONE
module rfdc_adc_integrator #(
   parameter int ACC_W = 48
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [255:0] s_axis_data_tdata,
   input  logic         s_axis_data_tvalid,
   output logic         s_axis_data_tready,
   input  logic [63:0]  timestamp,
   input  logic [63:0]  start_time,
   input  logic [31:0]  window_len,
   input  logic [15:0]  dc_offset,
   input  logic         arm,
   input  logic         abort,
   output logic         busy,
   output logic         ovf,
   output logic [63:0]  m_axis_result_tdata,
   output logic         m_axis_result_tvalid,
   input  logic         m_axis_result_tready
);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_INTEG, S_DRAIN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [63:0]        start_q, start_d;
   logic [31:0]        remain_q, remain_d;
   logic               drain_q, drain_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               tready_q;

   // beat pipeline: stage 1 holds corrected samples, stage 2 holds the beat sum
   logic [15:0][16:0]  d_q, d_d;
   logic               vld1_q, vld1_d;
   logic [20:0]        sum_q, sum_d;
   logic               vld2_q, vld2_d;

   logic               count_beat;
   logic [ACC_W:0]     acc_sum;
   logic               acc_ovf;
   logic [ACC_W-1:0]   acc_sat;

   // The cycle the start time is reached in ARMED already counts as a beat slot.
   assign count_beat = s_axis_data_tvalid &&
                       ((state_q == S_INTEG) || ((state_q == S_ARMED) && (timestamp >= start_q)));

   always_comb begin
      logic [16:0] dv;
      dv = '0;
      for (int k = 0; k < 16; k++) begin
         dv = {s_axis_data_tdata[16*k+15], s_axis_data_tdata[16*k +: 16]} - {dc_offset[15], dc_offset};
`ifdef RFDC_ADC_ABS_EN
         if (dv[16]) dv = -dv;
`endif
         d_d[k] = dv;
      end
   end

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < 16; k++) sum_d = sum_d + {{4{d_q[k][16]}}, d_q[k]};
   end

   assign vld1_d = count_beat && !abort;
   assign vld2_d = vld1_q && !abort;

   // one guard bit detects overflow; clamp to the signed extremes
   assign acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-20){sum_q[20]}}, sum_q};
   assign acc_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
   assign acc_sat = !acc_ovf      ? acc_sum[ACC_W-1:0] :
                    acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      remain_d = remain_q;
      drain_d  = drain_q;
      ovf_d    = ovf_q;
      acc_d    = acc_q;
      if (vld2_q) begin
         acc_d = acc_sat;
         if (acc_ovf) ovf_d = 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (arm && (window_len != 32'd0)) begin
               state_d  = S_ARMED;
               start_d  = start_time;
               remain_d = window_len;
               acc_d    = '0;
               ovf_d    = 1'b0;
            end
         end
         S_ARMED, S_INTEG: begin
            if (count_beat) begin
               remain_d = remain_q - 32'd1;
               if (remain_q == 32'd1) begin
                  state_d = S_DRAIN;
                  drain_d = 1'b0;
               end else begin
                  state_d = S_INTEG;
               end
            end else if (timestamp >= start_q) begin
               state_d = S_INTEG;
            end
         end
         S_DRAIN: begin
            // two cycles: the last beat leaves stage 2 into the accumulator
            if (drain_q) state_d = S_DONE;
            else         drain_d = 1'b1;
         end
         S_DONE: begin
            if (m_axis_result_tready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d  = S_IDLE;
         remain_d = '0;
         drain_d  = 1'b0;
         acc_d    = '0;
         ovf_d    = ovf_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         start_q  <= '0;
         remain_q <= '0;
         drain_q  <= 1'b0;
         ovf_q    <= 1'b0;
         acc_q    <= '0;
         tready_q <= 1'b0;
         d_q      <= '0;
         vld1_q   <= 1'b0;
         sum_q    <= '0;
         vld2_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         remain_q <= remain_d;
         drain_q  <= drain_d;
         ovf_q    <= ovf_d;
         acc_q    <= acc_d;
         tready_q <= 1'b1;
         d_q      <= d_d;
         vld1_q   <= vld1_d;
         sum_q    <= sum_d;
         vld2_q   <= vld2_d;
      end
   end

   assign s_axis_data_tready   = tready_q;
   assign busy                 = (state_q != S_IDLE);
   assign ovf                  = ovf_q;
   assign m_axis_result_tvalid = (state_q == S_DONE);
   assign m_axis_result_tdata  = 64'($signed(acc_q));

endmodule

// File: tb/tb_rfdc_adc_integrator.sv
module tb_rfdc_adc_integrator;
   localparam int     ACC_W = 24;
   localparam longint MAXV  = (longint'(1) <<< (ACC_W-1)) - 1;
   localparam longint MINV  = -(longint'(1) <<< (ACC_W-1));

   logic         clk = 1'b0;
   logic         resetn;
   logic [255:0] s_axis_data_tdata;
   logic         s_axis_data_tvalid;
   logic         s_axis_data_tready;
   logic [63:0]  timestamp;
   logic [63:0]  start_time;
   logic [31:0]  window_len;
   logic [15:0]  dc_offset;
   logic         arm, abort, busy, ovf;
   logic [63:0]  m_axis_result_tdata;
   logic         m_axis_result_tvalid;
   logic         m_axis_result_tready;

   int checks = 0;
   int errors = 0;

   rfdc_adc_integrator #(.ACC_W(ACC_W)) dut (
      .clk(clk), .resetn(resetn),
      .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
      .s_axis_data_tready(s_axis_data_tready),
      .timestamp(timestamp), .start_time(start_time), .window_len(window_len),
      .dc_offset(dc_offset), .arm(arm), .abort(abort), .busy(busy), .ovf(ovf),
      .m_axis_result_tdata(m_axis_result_tdata), .m_axis_result_tvalid(m_axis_result_tvalid),
      .m_axis_result_tready(m_axis_result_tready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock; inputs set before the call are sampled together with timestamp
   task automatic cyc();
      @(posedge clk);
      #1;
      timestamp = timestamp + 64'd1;
   endtask

   function automatic logic [255:0] mkbeat(input int mode, input int val);
      logic [255:0] b;
      for (int k = 0; k < 16; k++) begin
         case (mode)
            1:       b[16*k +: 16] = 16'(val);
            2:       b[16*k +: 16] = (k % 2 == 0) ? 16'd1000 : 16'hFC18;
            default: b[16*k +: 16] = 16'($urandom);
         endcase
      end
      return b;
   endfunction

   function automatic longint bsum(input logic [255:0] b, input logic [15:0] off);
      longint s = 0;
      for (int k = 0; k < 16; k++) begin
         logic [15:0] smp;
         smp = b[16*k +: 16];
         s += longint'($signed(smp)) - longint'($signed(off));
      end
      return s;
   endfunction

   task automatic rand_beat();
      s_axis_data_tdata  = mkbeat(0, 0);
      s_axis_data_tvalid = 1'($urandom_range(1));
   endtask

   // Arms one capture, feeds beats, and checks the result handshake.
   // The reference sums the first wlen valid beats at or after the start
   // time, clamping to the ACC_W signed range after every beat.
   // vprob < 0 selects the tvalid pattern 1,0,1,0,...
   task automatic capture(input string tag, input longint delay, input int wlen, input int vprob,
                          input int mode, input int val, input logic [15:0] off,
                          input bit use_k, input longint kval, input bit kovf,
                          input int hold, input bit arm_on_ack);
      longint exp, v;
      bit     oe;
      int     cnt, it;
      logic [63:0] st;
      st = timestamp + 64'(delay);
      start_time = st; window_len = 32'(wlen); dc_offset = off;
      s_axis_data_tvalid = 1'b0; arm = 1'b1;
      cyc();
      arm = 1'b0;
      chk({tag, ".busy_armed"}, 64'(busy), 64'd1);
      exp = 0; oe = 0; cnt = 0; it = 0;
      while (cnt < wlen && it < 3000) begin
         s_axis_data_tdata  = mkbeat(mode, val);
         s_axis_data_tvalid = (vprob < 0) ? (it % 2 == 0) : ($urandom_range(99) < vprob);
         if (s_axis_data_tvalid && timestamp >= st) begin
            cnt++;
            v = exp + bsum(s_axis_data_tdata, off);
            if (v > MAXV) begin v = MAXV; oe = 1; end
            if (v < MINV) begin v = MINV; oe = 1; end
            exp = v;
         end
         cyc();
         it++;
      end
      if (cnt < wlen) begin
         errors++;
         $error("FAIL %s.timeout: counted %0d beats, required %0d", tag, cnt, wlen);
      end
      chk({tag, ".lat1"}, 64'(m_axis_result_tvalid), 64'd0);
      rand_beat(); cyc();
      chk({tag, ".lat2"}, 64'(m_axis_result_tvalid), 64'd0);
      rand_beat(); cyc();
      chk({tag, ".lat3"}, 64'(m_axis_result_tvalid), 64'd1);
      chk({tag, ".data"}, m_axis_result_tdata, 64'(exp));
      chk({tag, ".ovf"},  64'(ovf), 64'(oe));
      if (use_k) begin
         chk({tag, ".data_k"}, m_axis_result_tdata, 64'(kval));
         chk({tag, ".ovf_k"},  64'(ovf), 64'(kovf));
      end
      for (int h = 0; h < hold; h++) begin
         m_axis_result_tready = 1'b0;
         rand_beat(); cyc();
         chk({tag, ".hold_vld"},  64'(m_axis_result_tvalid), 64'd1);
         chk({tag, ".hold_data"}, m_axis_result_tdata, 64'(exp));
      end
      m_axis_result_tready = 1'b1;
      if (arm_on_ack) begin
         arm = 1'b1; window_len = 32'd5; start_time = timestamp;
      end
      cyc();
      m_axis_result_tready = 1'b0; arm = 1'b0; s_axis_data_tvalid = 1'b0;
      chk({tag, ".ack_vld"},  64'(m_axis_result_tvalid), 64'd0);
      chk({tag, ".ack_busy"}, 64'(busy), 64'd0);
      chk({tag, ".idle_ovf"}, 64'(ovf), 64'(oe));
   endtask

   initial begin
      resetn = 1'b0; timestamp = 64'd1000; start_time = '0; window_len = '0;
      dc_offset = '0; arm = 1'b0; abort = 1'b0; m_axis_result_tready = 1'b0;
      s_axis_data_tdata = '0; s_axis_data_tvalid = 1'b0;
      #23;
      chk("rst.tready", 64'(s_axis_data_tready), 64'd0);
      chk("rst.busy",   64'(busy), 64'd0);
      chk("rst.ovf",    64'(ovf), 64'd0);
      chk("rst.vld",    64'(m_axis_result_tvalid), 64'd0);
      chk("rst.data",   m_axis_result_tdata, 64'd0);
      resetn = 1'b1;
      cyc();
      chk("rst.tready_up", 64'(s_axis_data_tready), 64'd1);

      // arm with zero length is ignored
      window_len = 32'd0; arm = 1'b1; cyc(); arm = 1'b0;
      chk("zero_len.busy", 64'(busy), 64'd0);

      capture("r042", 10, 4, 100, 1, 100, 16'd0, 1, 6400, 0, 3, 0);
      capture("r043", 0, 2, 100, 2, 0, 16'hFFFB, 1, 160, 0, 1, 0);
      capture("r044", 0, 3, -1, 0, 0, 16'h0123, 0, 0, 0, 0, 0);
      capture("r045", 2, 300, 100, 1, 32767, 16'd0, 1, MAXV, 1, 0, 0);

      // arm and abort together: abort wins and ovf survives
      arm = 1'b1; abort = 1'b1; window_len = 32'd5; start_time = timestamp;
      cyc();
      arm = 1'b0; abort = 1'b0;
      chk("arm_abort.busy", 64'(busy), 64'd0);
      chk("arm_abort.ovf",  64'(ovf), 64'd1);

      // a real arm clears ovf; abort mid-capture emits nothing
      arm = 1'b1; window_len = 32'd50; start_time = timestamp;
      cyc();
      arm = 1'b0;
      chk("abort.ovf_cleared", 64'(ovf), 64'd0);
      for (int i = 0; i < 6; i++) begin
         s_axis_data_tdata = mkbeat(1, 7); s_axis_data_tvalid = 1'b1; cyc();
      end
      // an arm while integrating must be ignored
      arm = 1'b1; window_len = 32'd2; cyc(); arm = 1'b0;
      chk("rearm.busy", 64'(busy), 64'd1);
      abort = 1'b1; cyc(); abort = 1'b0;
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.data", m_axis_result_tdata, 64'd0);
      for (int i = 0; i < 60; i++) begin
         rand_beat(); cyc();
         chk("abort.no_result", 64'(m_axis_result_tvalid), 64'd0);
      end
      s_axis_data_tvalid = 1'b0;

      capture("r047", 3, 5, 80, 0, 0, 16'h0040, 0, 0, 0, 20, 1);
      capture("past_start", -5, 3, 100, 0, 0, 16'hFF00, 0, 0, 0, 0, 0);

      for (int r = 0; r < 12; r++)
         capture("rand", longint'($urandom_range(5)), int'($urandom_range(8, 1)),
                 int'($urandom_range(100, 30)), 0, 0, 16'($urandom),
                 0, 0, 0, int'($urandom_range(3)), 0);

      // reset in the middle of a capture discards it
      arm = 1'b1; window_len = 32'd20; start_time = timestamp;
      cyc();
      arm = 1'b0;
      for (int i = 0; i < 4; i++) begin rand_beat(); cyc(); end
      resetn = 1'b0;
      cyc();
      chk("midrst.busy",   64'(busy), 64'd0);
      chk("midrst.tready", 64'(s_axis_data_tready), 64'd0);
      chk("midrst.data",   m_axis_result_tdata, 64'd0);
      resetn = 1'b1;
      for (int i = 0; i < 30; i++) begin
         rand_beat(); cyc();
         chk("midrst.no_result", 64'(m_axis_result_tvalid), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
